// File: rtl/opfetch_pkg.sv
// Shared types and helpers for the operand fetch sequencer: FSM states,
// default widths and the constant-operand table.
package opfetch_pkg;

    localparam int PTR_W     = 5;
    localparam int DATA_W    = 8;
    localparam int RF_ADDR_W = PTR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        CAPTURE,
        OUT
    } state_t;

    function automatic logic [DATA_W-1:0] const_value(input logic [3:0] idx);
        logic [DATA_W-1:0] val;
        case (idx)
            4'd0:    val = 8'd127;
            4'd1:    val = 8'd1;
            4'd2:    val = 8'd2;
            4'd3:    val = 8'd128;
            4'd4:    val = 8'd8;
            4'd5:    val = 8'd3;
            4'd6:    val = 8'd4;
            4'd7:    val = 8'd5;
            4'd8:    val = 8'd32;
            4'd9:    val = 8'd6;
            4'd10:   val = 8'd15;
            4'd11:   val = 8'd64;
            4'd12:   val = 8'd7;
            4'd13:   val = 8'd255;
            4'd14:   val = 8'd19;
            default: val = 8'd20;
        endcase
        return val;
    endfunction

    function automatic logic is_const(input logic [PTR_W-1:0] ptr);
        return ptr[PTR_W-1];
    endfunction

endpackage

// File: rtl/operand_fetch_seq.sv
// Resolves an instruction's two operand pointers into operand values, using
// the constant table directly and a single synchronous register-file read port.
module operand_fetch_seq
    import opfetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PTR_W-1:0]     ptr_a,
    input  logic [PTR_W-1:0]     ptr_b,
    output logic                 rf_rd_en,
    output logic [RF_ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]    rf_rd_data,
    output logic [DATA_W-1:0]    opa,
    output logic [DATA_W-1:0]    opb,
    output logic                 a_is_const,
    output logic                 b_is_const,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t                state_q, state_d;
    logic [RF_ADDR_W-1:0]  idx_a_q, idx_a_d;
    logic [RF_ADDR_W-1:0]  idx_b_q, idx_b_d;
    logic                  a_const_q, a_const_d;
    logic                  b_const_q, b_const_d;
    logic [DATA_W-1:0]     opa_q, opa_d;
    logic [DATA_W-1:0]     opb_q, opb_d;

    logic a_reg, b_reg, same;

    assign a_reg = !a_const_q;
    assign b_reg = !b_const_q;
    assign same  = a_reg && b_reg && (idx_a_q == idx_b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            a_const_q <= 1'b0;
            b_const_q <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            a_const_q <= a_const_d;
            b_const_q <= b_const_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
        end
    end

    // Read data returns one cycle after its strobe, so ISSUE_B collects the
    // A read and CAPTURE collects whichever read was issued last.
    always_comb begin
        state_d    = state_q;
        idx_a_d    = idx_a_q;
        idx_b_d    = idx_b_q;
        a_const_d  = a_const_q;
        b_const_d  = b_const_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_a_d   = ptr_a[RF_ADDR_W-1:0];
                    idx_b_d   = ptr_b[RF_ADDR_W-1:0];
                    a_const_d = is_const(ptr_a);
                    b_const_d = is_const(ptr_b);
                    if (is_const(ptr_a)) opa_d = const_value(ptr_a[RF_ADDR_W-1:0]);
                    if (is_const(ptr_b)) opb_d = const_value(ptr_b[RF_ADDR_W-1:0]);
                    if (!is_const(ptr_a))      state_d = ISSUE_A;
                    else if (!is_const(ptr_b)) state_d = ISSUE_B;
                    else                       state_d = OUT;
                end
            end
            ISSUE_A: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = idx_a_q;
                state_d    = (b_reg && !same) ? ISSUE_B : CAPTURE;
            end
            ISSUE_B: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = idx_b_q;
                if (a_reg) opa_d = rf_rd_data;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                if (same) begin
                    opa_d = rf_rd_data;
                    opb_d = rf_rd_data;
                end else if (b_reg) begin
                    opb_d = rf_rd_data;
                end else begin
                    opa_d = rf_rd_data;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign opa        = opa_q;
    assign opb        = opb_q;
    assign a_is_const = a_const_q;
    assign b_is_const = b_const_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed self-checking bench for operand_fetch_seq with a small synchronous
// register-file model on the read port.
module tb_operand_fetch_seq;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] ptr_a;
    logic [4:0] ptr_b;
    logic       rf_rd_en;
    logic [3:0] rf_rd_addr;
    logic [7:0] rf_rd_data;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       a_is_const;
    logic       b_is_const;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] rfMem [16];

    int checks;
    int errors;

    operand_fetch_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ptr_a      (ptr_a),
        .ptr_b      (ptr_b),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .opa        (opa),
        .opb        (opb),
        .a_is_const (a_is_const),
        .b_is_const (b_is_const),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with one-cycle read latency
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rfMem[rf_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request, counts cycles from the accept edge to out_valid,
    // logs every read strobe, then checks latency, reads and the outputs.
    task automatic applyStimulus(input string name, input logic [4:0] pa, input logic [4:0] pb,
                                 input int expLat, input int expReads,
                                 input logic [3:0] expAddr0, input logic [3:0] expAddr1,
                                 input logic [7:0] expOpa, input logic [7:0] expOpb,
                                 input logic expAc, input logic expBc);
        int cycle;
        int reads;
        logic [3:0] addrLog [2];
        addrLog[0] = '0;
        addrLog[1] = '0;
        reads = 0;
        @(negedge clk);
        req_valid = 1'b1;
        ptr_a     = pa;
        ptr_b     = pb;
        checkOutput({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ptr_a     = 5'(($urandom));
        ptr_b     = 5'(($urandom));
        cycle     = 1;
        while (!out_valid && cycle < 12) begin
            if (rf_rd_en) begin
                if (reads < 2) addrLog[reads] = rf_rd_addr;
                reads++;
            end
            @(negedge clk);
            cycle++;
        end
        checkOutput({name, " latency"}, cycle, expLat);
        checkOutput({name, " reads"}, reads, expReads);
        if (expReads > 0) checkOutput({name, " addr0"}, {28'b0, addrLog[0]}, {28'b0, expAddr0});
        if (expReads > 1) checkOutput({name, " addr1"}, {28'b0, addrLog[1]}, {28'b0, expAddr1});
        checkOutput({name, " opa"}, {24'b0, opa}, {24'b0, expOpa});
        checkOutput({name, " opb"}, {24'b0, opb}, {24'b0, expOpb});
        checkOutput({name, " a_is_const"}, {31'b0, a_is_const}, {31'b0, expAc});
        checkOutput({name, " b_is_const"}, {31'b0, b_is_const}, {31'b0, expBc});
        @(negedge clk);
        checkOutput({name, " idle after"}, {30'b0, req_ready, out_valid}, 32'd2);
        checkOutput({name, " opa held"}, {24'b0, opa}, {24'b0, expOpa});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        ptr_a     = '0;
        ptr_b     = '0;
        out_ready = 1'b1;
        rf_rd_data = '0;
        for (int i = 0; i < 16; i++) rfMem[i] = 8'hE0 + 8'(i);
        rfMem[3] = 8'h5A;
        rfMem[9] = 8'hC3;
        rfMem[7] = 8'h11;
        rfMem[2] = 8'h80;

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset rd", {27'b0, rf_rd_en, rf_rd_addr}, 32'd0);
        checkOutput("reset operands", {16'b0, opa, opb}, 32'd0);
        checkOutput("reset flags", {30'b0, a_is_const, b_is_const}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release req_ready", {31'b0, req_ready}, 32'd1);

        applyStimulus("const", 5'b10000, 5'b11101, 1, 0, 4'd0, 4'd0, 8'd127, 8'd255, 1'b1, 1'b1);
        applyStimulus("two_reg", 5'd3, 5'd9, 4, 2, 4'd3, 4'd9, 8'h5A, 8'hC3, 1'b0, 1'b0);
        applyStimulus("same_reg", 5'd7, 5'd7, 3, 1, 4'd7, 4'd0, 8'h11, 8'h11, 1'b0, 1'b0);
        applyStimulus("mixed", 5'b11110, 5'd2, 3, 1, 4'd2, 4'd0, 8'd19, 8'h80, 1'b1, 1'b0);

        // Backpressure: hold out_ready low with a second request waiting
        out_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        ptr_a     = 5'd3;
        ptr_b     = 5'd9;
        @(posedge clk);
        @(negedge clk);
        ptr_a = 5'b10001;
        ptr_b = 5'b10011;
        begin
            int waitCycles;
            waitCycles = 0;
            while (!out_valid && waitCycles < 10) begin
                @(negedge clk);
                waitCycles++;
            end
            checkOutput("bp reach out", {31'b0, out_valid}, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp hold", {15'b0, out_valid, req_ready, opa, opb}, {15'b0, 1'b1, 1'b0, 8'h5A, 8'hC3});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp idle", {30'b0, req_ready, out_valid}, 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bp second valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp second ops", {16'b0, opa, opb}, {16'b0, 8'd1, 8'd128});
        checkOutput("bp second flags", {30'b0, a_is_const, b_is_const}, 32'd3);
        @(negedge clk);

        // Reset while the B read is in flight
        @(negedge clk);
        req_valid = 1'b1;
        ptr_a     = 5'd3;
        ptr_b     = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid issue_b", {27'b0, rf_rd_en, rf_rd_addr}, {27'b0, 1'b1, 4'd9});
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst outs", {26'b0, out_valid, rf_rd_en, rf_rd_addr}, 32'd0);
        checkOutput("mid rst operands", {16'b0, opa, opb}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid rst req_ready", {30'b0, req_ready, out_valid}, 32'd2);
        applyStimulus("post_rst", 5'd7, 5'd7, 3, 1, 4'd7, 4'd0, 8'h11, 8'h11, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
